mio_responder: RTL and testbench
================================

Name: mio_responder

Overview:
Memory/IO bus responder that sits on the CPU's memory interface and serves every instruction fetch and data access. It decodes the CPU address into word RAM or a small IO register region, inserts a programmable number of wait states, and returns data to the CPU's Data_in through a four-phase req/ready handshake. The block drives the CPU's MIO_ready input.

Parameters:
ADDR_W, 10, RAM word-index width; the RAM holds 2^ADDR_W 32-bit words
WAIT_CYCLES, 2, wait states between request acceptance and the access commit; legal range 0..15
LED_W, 16, width of the LED output register

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_req  input  1  CPU access request; level signal held until MIO_ready is seen
mem_w  input  1  1 = write, 0 = read; sampled with mem_req
addr  input  32  byte address from the CPU's Addr_out
wdata  input  32  write data from the CPU's Data_out
rdata  output  32  read data, drives the CPU's Data_in
MIO_ready  output  1  access complete; rdata is valid while this is high
sw  input  16  switch inputs, readable through the IO region
led  output  LED_W  LED register contents
busy  output  1  high in states WAIT and RESP

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, MIO_ready=0, rdata=0, led=0, cycle counter=0, wait counter=0. RAM contents are not reset.
- Reset asserted mid-transaction: any uncommitted write is discarded; the block returns to IDLE immediately.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when mem_req=1 at an edge, latch addr, mem_w and wdata into internal registers. Load the wait counter with WAIT_CYCLES and go to WAIT.
  - WAIT: at each edge, if the counter is 0, commit the access and go to RESP; otherwise decrement the counter.
  - RESP: MIO_ready=1. Stay in RESP while mem_req=1. Return to IDLE at the first edge where mem_req=0.
- Latency: mem_req sampled at edge k gives MIO_ready=1 after edge k+WAIT_CYCLES+1. WAIT_CYCLES=0 gives one cycle of latency.
- Commit uses only the latched values. Changes on addr, mem_w or wdata after acceptance are ignored.
  - Write commit: update the target location. rdata is set to the latched wdata.
  - Read commit: set rdata to the target data.
  - rdata holds its value until the next commit.
- Address decode (latched address):
  - addr[31:28]==4'hE selects the IO region; all other addresses select RAM.
  - RAM index = addr[ADDR_W+1:2]. Upper bits are ignored, so accesses alias and wrap. addr[1:0] is ignored, so there are no byte lanes and no misalignment fault.
  - IO offset 0x0: LED register. Read/write. Reads zero-extend to 32 bits; writes take wdata[LED_W-1:0].
  - IO offset 0x4: switches. Reads return {16'b0, sw} sampled at commit. Writes are ignored.
  - IO offset 0x8: cycle counter, 32-bit free-running. Reads return its value. A write loads it with wdata.
  - All other IO offsets (addr[27:0]): reads return 0, writes are ignored, and the handshake still completes.
- Cycle counter:
  - Increments every clock and wraps from 0xFFFFFFFF to 0.
  - Write and increment in the same cycle: the write wins, and the counter equals wdata at the next edge.
- mem_req dropping during WAIT: the access still commits and RESP is entered. If mem_req=0 in RESP, the FSM goes to IDLE on the next edge (MIO_ready is high for one cycle).
- Back-to-back: a new request is accepted only from IDLE, so there is at least one IDLE cycle between transactions.

Test Plan:
- Reset/defaults: hold reset=0 for 3 cycles and release -> MIO_ready=0, rdata=0, led=0, busy=0. Read IO 0xE0000008 immediately -> returns a small count consistent with the release time.
- RAM write/read, WAIT_CYCLES=2: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> MIO_ready rises 3 cycles after each request edge and the read returns 0xDEADBEEF. Read 0x00001010 with ADDR_W=10 -> aliases and returns 0xDEADBEEF.
- IO access: write 0x0001A5A5 to 0xE0000000 -> led=0xA5A5. Set sw=0x1234 and read 0xE0000004 -> 0x00001234. Write to 0xE0000004 -> sw readback is unchanged. Read 0xE0000020 -> 0 with a completed handshake.
- Counter: write 0xFFFFFFFE to 0xE0000008 -> the counter wraps to 0 two cycles after the commit. A subsequent read returns the expected small value.
- Handshake edges: hold mem_req high for 5 cycles after MIO_ready -> MIO_ready stays high and there is no second access. Drop mem_req during WAIT -> the write still lands and MIO_ready pulses for one cycle. Change addr during WAIT -> the original address is used.
- Reset mid-write: assert reset while in WAIT during a write of 0x55 to 0x20 -> RAM[8] keeps its prior value and the FSM is in IDLE after release. Repeat with WAIT_CYCLES=0 -> MIO_ready 1 cycle after the request edge.

Source files
------------

// File: rtl/mio_responder.sv
// CPU memory/IO responder: decodes the latched bus address into word RAM or a small
// IO register file, inserts WAIT_CYCLES wait states, then answers with a req/ready handshake.
module mio_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned LED_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_req,
    input  logic             mem_w,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             MIO_ready,
    input  logic [15:0]      sw,
    output logic [LED_W-1:0] led,
    output logic             busy
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_W;
    localparam int unsigned WAIT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         lat_addr;
    logic                lat_w;
    logic [31:0]         lat_wdata;
    logic [31:0]         cycle_cnt;
    logic [31:0]         ram [RAM_DEPTH];

    logic                commit_c;
    logic                io_sel_c;
    logic [27:0]         io_off_c;
    logic [ADDR_W-1:0]   ram_idx_c;
    logic                ram_we_c;
    logic                cnt_we_c;
    logic                led_we_c;
    logic [31:0]         rd_val_c;

    // Decode of the latched access; only the registered copies feed the commit.
    always_comb begin
        commit_c  = (state == WAIT) && (wait_cnt == WAIT_W'(0));
        io_sel_c  = (lat_addr[31:28] == 4'hE);
        io_off_c  = lat_addr[27:0];
        ram_idx_c = lat_addr[ADDR_W+1:2];
        ram_we_c  = commit_c && lat_w && !io_sel_c;
        led_we_c  = commit_c && lat_w && io_sel_c && (io_off_c == 28'h0);
        cnt_we_c  = commit_c && lat_w && io_sel_c && (io_off_c == 28'h8);
    end

    // Read mux; unmapped IO offsets read as zero.
    always_comb begin
        rd_val_c = 32'd0;
        if (io_sel_c) begin
            case (io_off_c)
                28'h0:   rd_val_c = 32'(led);
                28'h4:   rd_val_c = {16'd0, sw};
                28'h8:   rd_val_c = cycle_cnt;
                default: rd_val_c = 32'd0;
            endcase
        end else begin
            rd_val_c = ram[ram_idx_c];
        end
    end

    // Handshake FSM with latched request and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= WAIT_W'(0);
            lat_addr  <= 32'd0;
            lat_w     <= 1'b0;
            lat_wdata <= 32'd0;
            rdata     <= 32'd0;
            MIO_ready <= 1'b0;
            busy      <= 1'b0;
            led       <= LED_W'(0);
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        lat_addr  <= addr;
                        lat_w     <= mem_w;
                        lat_wdata <= wdata;
                        wait_cnt  <= WAIT_W'(WAIT_CYCLES);
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (commit_c) begin
                        rdata     <= lat_w ? lat_wdata : rd_val_c;
                        MIO_ready <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                RESP: begin
                    if (!mem_req) begin
                        MIO_ready <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    MIO_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
            if (led_we_c) begin
                led <= lat_wdata[LED_W-1:0];
            end
        end
    end

    // Free-running cycle counter; a bus write takes priority over the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= 32'd0;
        end else if (cnt_we_c) begin
            cycle_cnt <= lat_wdata;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Word RAM is not reset; a reset during WAIT forces IDLE so no write can land.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[ram_idx_c] <= lat_wdata;
        end
    end

endmodule

// File: tb/tb_mio_responder.sv
// Directed bench for mio_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_mio_responder;

    logic        clk;
    logic        reset;
    logic [15:0] sw;

    logic        mem_req, mem_w;
    logic [31:0] addr, wdata, rdata;
    logic        MIO_ready, busy;
    logic [15:0] led;

    logic        req0, w0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        ready0, busy0;
    logic [15:0] led0;

    int checks = 0;
    int errors = 0;

    mio_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .LED_W(16)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_w(mem_w), .addr(addr),
        .wdata(wdata), .rdata(rdata), .MIO_ready(MIO_ready), .sw(sw), .led(led), .busy(busy)
    );

    mio_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .LED_W(16)) dut0 (
        .clk(clk), .reset(reset), .mem_req(req0), .mem_w(w0), .addr(addr0),
        .wdata(wdata0), .rdata(rdata0), .MIO_ready(ready0), .sw(sw), .led(led0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit u0);
        return u0 ? ready0 : MIO_ready;
    endfunction

    task automatic drive(input bit u0, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        if (u0) begin
            req0 = r; w0 = w; addr0 = a; wdata0 = d;
        end else begin
            mem_req = r; mem_w = w; addr = a; wdata = d;
        end
    endtask

    // Full transaction; lat = request-accept edges until MIO_ready, -1 on timeout.
    task automatic access(input bit u0, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat);
        @(negedge clk);
        drive(u0, 1'b1, w, a, d);
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy(u0)) begin
                lat = i;
                break;
            end
        end
        rd = u0 ? rdata0 : rdata;
        drive(u0, 1'b0, 1'b0, a, d);
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n);
        n = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (MIO_ready) begin
                n = i;
                break;
            end
        end
    endtask

    logic [31:0] rd;
    int          lat;

    initial begin
        reset = 1'b0;
        sw    = 16'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        chk("rst_ready", 32'(MIO_ready), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // One edge after release, then accept, 2 waits, commit samples count 4.
        access(1'b0, 1'b0, 32'hE000_0008, 32'h0, rd, lat);
        chk("cnt_after_reset", rd, 32'd4);

        access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, lat);
        chk("ram_wr_lat", 32'(lat), 32'd3);
        chk("ram_wr_rdata", rd, 32'hDEAD_BEEF);
        access(1'b0, 1'b0, 32'h0000_0010, 32'h0, rd, lat);
        chk("ram_rd_lat", 32'(lat), 32'd3);
        chk("ram_rd", rd, 32'hDEAD_BEEF);
        access(1'b0, 1'b0, 32'h0000_1013, 32'h0, rd, lat);
        chk("ram_alias", rd, 32'hDEAD_BEEF);
        chk("idle_busy", 32'(busy), 32'd0);

        access(1'b0, 1'b1, 32'hE000_0000, 32'h0001_A5A5, rd, lat);
        chk("led_wr", 32'(led), 32'h0000_A5A5);
        access(1'b0, 1'b0, 32'hE000_0000, 32'h0, rd, lat);
        chk("led_rd", rd, 32'h0000_A5A5);
        sw = 16'h1234;
        access(1'b0, 1'b0, 32'hE000_0004, 32'h0, rd, lat);
        chk("sw_rd", rd, 32'h0000_1234);
        access(1'b0, 1'b1, 32'hE000_0004, 32'h0000_FFFF, rd, lat);
        access(1'b0, 1'b0, 32'hE000_0004, 32'h0, rd, lat);
        chk("sw_rd_after_wr", rd, 32'h0000_1234);
        access(1'b0, 1'b0, 32'hE000_0020, 32'h0, rd, lat);
        chk("io_unmapped_lat", 32'(lat), 32'd3);
        chk("io_unmapped_rd", rd, 32'd0);

        // Counter = FFFFFFFE at commit, wraps two edges later, read commits 3 edges after that.
        access(1'b0, 1'b1, 32'hE000_0008, 32'hFFFF_FFFE, rd, lat);
        access(1'b0, 1'b0, 32'hE000_0008, 32'h0, rd, lat);
        chk("cnt_wrap_rd", rd, 32'd3);

        // Hold mem_req for 5 cycles in RESP; changing wdata must not cause a second access.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_1111);
        wait_ready(lat);
        chk("hold_lat", 32'(lat), 32'd3);
        wdata = 32'h2222_2222;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(MIO_ready), 32'd1);
        end
        chk("hold_rdata", rdata, 32'h1111_1111);
        mem_req = 1'b0;
        @(negedge clk);
        chk("hold_release", 32'(MIO_ready), 32'd0);
        access(1'b0, 1'b0, 32'h0000_0040, 32'h0, rd, lat);
        chk("hold_single_wr", rd, 32'h1111_1111);

        // Drop mem_req during WAIT: write lands, MIO_ready pulses one cycle.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h3333_3333);
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd1);
        mem_req = 1'b0;
        wait_ready(lat);
        chk("drop_lat", 32'(lat + 1), 32'd3);
        @(negedge clk);
        chk("drop_pulse", 32'(MIO_ready), 32'd0);
        access(1'b0, 1'b0, 32'h0000_0080, 32'h0, rd, lat);
        chk("drop_wr", rd, 32'h3333_3333);

        // Address/data change during WAIT is ignored.
        access(1'b0, 1'b1, 32'h0000_00C4, 32'h0BAD_0BAD, rd, lat);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_00C0, 32'h4444_4444);
        @(negedge clk);
        addr  = 32'h0000_00C4;
        wdata = 32'h0000_0099;
        wait_ready(lat);
        chk("chg_rdata", rdata, 32'h4444_4444);
        mem_req = 1'b0;
        @(negedge clk);
        access(1'b0, 1'b0, 32'h0000_00C0, 32'h0, rd, lat);
        chk("chg_orig", rd, 32'h4444_4444);
        access(1'b0, 1'b0, 32'h0000_00C4, 32'h0, rd, lat);
        chk("chg_other", rd, 32'h0BAD_0BAD);

        // Prime RAM[8] on both instances, then reset in the middle of a write.
        access(1'b0, 1'b1, 32'h0000_0020, 32'hAAAA_0000, rd, lat);
        access(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0077, rd, lat);
        chk("w0_wr_lat", 32'(lat), 32'd1);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, rd, lat);
        chk("w0_rd_lat", 32'(lat), 32'd1);
        chk("w0_rd", rd, 32'h0000_0077);

        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_busy0", 32'(busy0), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready0", 32'(ready0), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_busy0", 32'(busy0), 32'd0);
        chk("post_rst_led", 32'(led), 32'd0);
        access(1'b0, 1'b0, 32'h0000_0020, 32'h0, rd, lat);
        chk("mid_rst_ram", rd, 32'hAAAA_0000);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, rd, lat);
        chk("mid_rst_ram0", rd, 32'h0000_0077);
        chk("post_rst_lat0", 32'(lat), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
